// File: rtl/int2float_pkg.sv
// Shared definitions for the int2float round-robin scheduler: widths, result type
// and a reference conversion function.
package int2float_pkg;

    localparam int INT_W  = 11;
    localparam int MANT_W = 4;
    localparam int EXP_W  = 3;

    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float7_t;

    // Truncating conversion: the value is approximated as mant << exp.
    function automatic float7_t int2float(input logic [INT_W-1:0] x);
        float7_t r;
        r.exp  = '0;
        r.mant = x[MANT_W-1:0];
        for (int p = MANT_W; p < INT_W; p++) begin
            if (x[p]) begin
                r.exp  = EXP_W'(p - (MANT_W - 1));
                r.mant = MANT_W'(x >> (p - (MANT_W - 1)));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/int2float_conv.sv
// Purely combinational 11-bit unsigned integer to 3-bit exponent / 4-bit mantissa
// converter; truncates the bits below the leading four.
module int2float_conv
    import int2float_pkg::*;
(
    input  logic [INT_W-1:0] x,
    output float7_t          y
);

    logic [3:0] msb_pos;
    logic       big;

    // Locate the most significant set bit; values below 16 need no normalisation.
    always_comb begin
        msb_pos = 4'd0;
        for (int p = 0; p < INT_W; p++) begin
            if (x[p]) begin
                msb_pos = 4'(p);
            end
        end
        big = (msb_pos >= 4'(MANT_W));
    end

    always_comb begin
        y.exp  = '0;
        y.mant = x[MANT_W-1:0];
        if (big) begin
            y.exp  = EXP_W'(msb_pos - 4'(MANT_W - 1));
            y.mant = MANT_W'(x >> (msb_pos - 4'(MANT_W - 1)));
        end
    end

endmodule

// File: rtl/int2float_rr_sched.sv
// Round-robin scheduler sharing one int-to-float converter among N_REQ requesters,
// with a single registered result slot and valid/ready backpressure.
module int2float_rr_sched
    import int2float_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*INT_W-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [MANT_W-1:0]        resp_mant,
    output logic [EXP_W-1:0]         resp_exp,
    output logic                     busy
);

    localparam logic [ID_W:0] N_WIDE = (ID_W+1)'(N_REQ);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_next;
    logic [N_REQ-1:0] rot_valid;
    logic [ID_W:0]    idx;
    logic [ID_W:0]    sum;
    logic [ID_W-1:0]  offset;
    logic [ID_W-1:0]  winner;
    logic             any_valid;
    logic             can_load;
    logic             accept;
    logic [INT_W-1:0] winner_data;
    float7_t          conv_out;
    float7_t          resp_res;

    // Rotate the valid vector so position 0 is the pointer, then pick the lowest
    // set position; modulo arithmetic keeps non-power-of-two N_REQ in range.
    always_comb begin
        rot_valid = '0;
        idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= N_WIDE) begin
                idx = idx - N_WIDE;
            end
            rot_valid[i] = req_valid[idx[ID_W-1:0]];
        end
        any_valid = |rot_valid;
        offset    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                offset = ID_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= N_WIDE) begin
            sum = sum - N_WIDE;
        end
        winner = sum[ID_W-1:0];
    end

    always_comb begin
        can_load  = ~resp_valid | resp_ready;
        accept    = any_valid & can_load;
        req_ready = accept ? (N_REQ'(1) << winner) : '0;
        ptr_next  = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        busy      = resp_valid | (|req_valid);
    end

    assign winner_data = req_data[INT_W*int'(winner) +: INT_W];

    int2float_conv u_conv (
        .x (winner_data),
        .y (conv_out)
    );

    // Result slot: reload on accept (even while draining), clear valid on a bare drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_res   <= '0;
            ptr        <= '0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_id    <= winner;
            resp_res   <= conv_out;
            ptr        <= ptr_next;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign resp_exp  = resp_res.exp;
    assign resp_mant = resp_res.mant;

endmodule

// File: doc/int2float_rr_sched.md
# int2float_rr_sched

Round-robin scheduler that shares one combinational 11-bit-integer-to-float converter among N_REQ requesters. Each requester presents an unsigned 11-bit integer with a valid/ready handshake. The block grants one requester per cycle and registers the converted 3-bit exponent / 4-bit mantissa result with the winner's ID. It delivers the result downstream over a valid/ready response port with full backpressure.

## Interface
- N_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(N_REQ) (derived, not overridable), width of requester ID
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  N_REQ*11  packed operands; requester i at [11*i+10:11*i]
- req_ready  out  N_REQ  one-hot-or-zero accept strobe
- resp_valid  out  1  result register holds a valid result
- resp_ready  in  1  downstream accepts result
- resp_id  out  ID_W  index of the requester the result belongs to
- resp_mant  out  4  mantissa M3..M0
- resp_exp  out  3  exponent E2..E0
- busy  out  1  resp_valid OR any req_valid

## Operation
- Conversion, truncating:
  - x < 16: exp=0, mant=x[3:0].
  - x ≥ 16: p = index of MSB set; exp = p-3 (1..7); mant = x[p:p-3].
  - Value approximated as mant<<exp.
- Arbitration:
  - Round-robin pointer ptr (ID_W bits).
  - Winner = first i with req_valid[i], searching ptr, ptr+1, … modulo N_REQ.
  - No valid requesters: no grant.
- can_load = ~resp_valid | resp_ready.
- req_ready[winner] = can_load. All other req_ready bits are 0. req_ready never depends on req_data.
- Accept event = req_valid[w] & req_ready[w]. On accept:
  - Result register loads {id=w, exp, mant} of req_data[w]; resp_valid←1.
  - ptr←(w+1) mod N_REQ; wrap from N_REQ-1 to 0. For non-power-of-two N_REQ, never advance ptr beyond N_REQ-1.
- resp_valid & resp_ready with no accept in the same cycle: resp_valid←0. Data fields hold their last value.
- Simultaneous drain and accept: the register reloads; resp_valid stays 1. Zero-bubble throughput is 1 result/cycle.
- Response stall (resp_valid & ~resp_ready): register and ptr frozen; all req_ready 0.
- Requester dropping req_valid before acceptance is legal. Arbitration re-evaluates every cycle; the pointer moves only on accept.
- Requester state machine (per requester, implied by protocol): IDLE→WAIT on req_valid; WAIT→IDLE on accept. No starvation: any asserted request is served within N_REQ accepts.

## Timing
- Reset values (asynchronous, immediate): resp_valid=0, resp_id=0, resp_exp=0, resp_mant=0, ptr=0. req_ready then follows the combinational rule (can_load=1).
- Latency: 1 cycle. Result visible on resp_* the cycle after the accept edge.
- req_ready is combinational from req_valid, ptr, resp_valid and resp_ready. No combinational path from req_data to any ready.
- Reset mid-operation: the pending result is discarded; ptr returns to 0; no response is emitted for an in-flight accept.

## Structure
- Shared package int2float_pkg:
  - constants INT_W=11, MANT_W=4, EXP_W=3.
  - typedef float7_t {exp, mant}.
  - function for exp/mant reference model, reused by the bench scoreboard.
- Sub-module int2float_conv: purely combinational 11→7 converter, one instance.
- Top contains:
  - winner mux and arbiter, rotate-then-priority-encode.
  - pointer register.
  - result register.

## Test plan
- Single requester 0, data 5, resp_ready=1 → next cycle resp_valid=1, id=0, exp=0, mant=5.
- Boundaries, one at a time:
  - data 16 → exp=1, mant=8.
  - data 1000 → exp=6, mant=15.
  - data 2047 → exp=7, mant=15.
  - data 0 → exp=0, mant=0.
- All 4 requesters valid continuously, resp_ready=1 → ids 0,1,2,3,0,… one per cycle, no bubbles.
- resp_ready held 0 for 3 cycles with requesters 1 and 2 valid → result frozen, req_ready=0 throughout. On release, id order continues 2 then 1 (per ptr), with no loss or duplication.
- Drain and accept in the same cycle → resp_valid stays 1; new id/data appear next cycle.
- rst_n pulsed low while resp_valid=1 and ptr=2 → resp_valid=0 immediately; first grant after reset goes to the lowest-index valid requester from 0.
